// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN feature-map pipeline.
// The package has no ports. It provides:
//   CONV1_OUT_W, CONV1_OUT_H : conv1 output geometry (24x24)
//   CONV_DATA_BITS           : sample width for conv results (15)
//   POOL1_OUT_W              : pooled row width after 2x2/stride-2 (12)
//   relu()                   : clamps negative two's-complement values to zero
package cnn_pkg;

  localparam int CONV1_OUT_W    = 24;
  localparam int CONV1_OUT_H    = 24;
  localparam int CONV_DATA_BITS = 15;
  localparam int POOL1_OUT_W    = 12;

  // relu() works at 32 bits so that any sample width can use it. Callers
  // sign-extend their sample on the way in and truncate on the way out.
  function automatic logic [31:0] relu(input logic signed [31:0] x);
    return x[31] ? 32'd0 : 32'(x);
  endfunction

endpackage

// File: rtl/pool2x2_channel.sv
// One channel of ReLU + 2x2/stride-2 max-pooling.
// Position information comes from counters shared in the parent.
// Ports:
//   clk, rst_n  : clock and asynchronous active-high reset (rst_n = 1 resets)
//   accept_i    : a sample is being consumed this cycle
//   col_odd_i   : col[0] of the accepted sample
//   row_odd_i   : row[0] of the accepted sample
//   lb_addr_i   : col >> 1, which selects the line-buffer entry
//   din_i       : signed conv sample
//   pool_o      : registered pooled value, held between strobes
module pool2x2_channel
  import cnn_pkg::*;
#(
  parameter int DATA_BITS = CONV_DATA_BITS,
  parameter int LB_DEPTH  = POOL1_OUT_W,
  parameter int LB_AW     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 accept_i,
  input  logic                 col_odd_i,
  input  logic                 row_odd_i,
  input  logic [LB_AW-1:0]     lb_addr_i,
  input  logic [DATA_BITS-1:0] din_i,
  output logic [DATA_BITS-1:0] pool_o
);

  logic [DATA_BITS-1:0] r;
  logic [DATA_BITS-1:0] hmax;
  logic [DATA_BITS-1:0] lb_rd;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [DATA_BITS-1:0] pool_q, pool_d;
  logic                 lb_we;
  logic [DATA_BITS-1:0] lb_q [LB_DEPTH];

  always_comb begin
    r      = DATA_BITS'(relu(32'($signed(din_i))));
    // After ReLU the MSB is always 0, so unsigned compares are safe.
    hmax   = (r > hold_q) ? r : hold_q;
    lb_rd  = lb_q[lb_addr_i];
    hold_d = hold_q;
    pool_d = pool_q;
    lb_we  = accept_i && col_odd_i && !row_odd_i;
    if (accept_i && !col_odd_i) begin
      hold_d = r;
    end
    if (accept_i && col_odd_i && row_odd_i) begin
      pool_d = (lb_rd > hmax) ? lb_rd : hmax;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hold_q <= '0;
      pool_q <= '0;
    end else begin
      hold_q <= hold_d;
      pool_q <= pool_d;
    end
  end

  // The line buffer is not reset. Each entry is written on an even row
  // before the odd row of the same frame reads it.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[lb_addr_i] <= hmax;
    end
  end

  assign pool_o = pool_q;

endmodule

// File: rtl/maxpool_relu1.sv
// ReLU + 2x2/stride-2 max-pool across the three conv1 output channels.
// Input is raster-ordered and qualified by valid_in; gaps are allowed.
// Ports:
//   clk, rst_n             : clock and asynchronous active-high reset (rst_n = 1 resets)
//   valid_in               : conv_in_1..3 carry a pixel this cycle
//   conv_in_1..3           : signed conv results for the same pixel position
//   pool_out_1..3          : pooled, ReLU'd outputs (MSB always 0)
//   valid_out_pool         : one-cycle strobe qualifying pool_out_*
//   frame_done             : strobe on the last pooled output of a frame
module maxpool_relu1
  import cnn_pkg::*;
#(
  parameter int WIDTH     = CONV1_OUT_W,
  parameter int HEIGHT    = CONV1_OUT_H,
  parameter int DATA_BITS = CONV_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] conv_in_1,
  input  logic [DATA_BITS-1:0] conv_in_2,
  input  logic [DATA_BITS-1:0] conv_in_3,
  output logic [DATA_BITS-1:0] pool_out_1,
  output logic [DATA_BITS-1:0] pool_out_2,
  output logic [DATA_BITS-1:0] pool_out_3,
  output logic                 valid_out_pool,
  output logic                 frame_done
);

  localparam int CW    = $clog2(WIDTH);
  localparam int RW    = $clog2(HEIGHT);
  localparam int LB_AW = CW - 1;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          col_last, row_last;

  logic [DATA_BITS-1:0] din  [3];
  logic [DATA_BITS-1:0] dout [3];

  always_comb begin
    col_last = (col_q == CW'(WIDTH - 1));
    row_last = (row_q == RW'(HEIGHT - 1));
    col_d    = col_q;
    row_d    = row_q;
    if (valid_in) begin
      if (col_last) begin
        col_d = '0;
        // The row counter wraps, so the next frame can follow with no idle cycle.
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    // An odd row and odd column mark the bottom-right pixel of a 2x2 window.
    valid_d = valid_in && col_q[0] && row_q[0];
    done_d  = valid_in && col_last && row_last;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign din[0] = conv_in_1;
  assign din[1] = conv_in_2;
  assign din[2] = conv_in_3;

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    pool2x2_channel #(
      .DATA_BITS (DATA_BITS),
      .LB_DEPTH  (WIDTH / 2),
      .LB_AW     (LB_AW)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .accept_i  (valid_in),
      .col_odd_i (col_q[0]),
      .row_odd_i (row_q[0]),
      .lb_addr_i (col_q[CW-1:1]),
      .din_i     (din[ch]),
      .pool_o    (dout[ch])
    );
  end

  assign pool_out_1     = dout[0];
  assign pool_out_2     = dout[1];
  assign pool_out_3     = dout[2];
  assign valid_out_pool = valid_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_maxpool_relu1.sv
module tb_maxpool_relu1;

  localparam int W  = 24;
  localparam int H  = 24;
  localparam int DB = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          valid_in = 1'b0;
  logic [DB-1:0] conv_in_1 = '0, conv_in_2 = '0, conv_in_3 = '0;
  logic [DB-1:0] pool_out_1, pool_out_2, pool_out_3;
  logic          valid_out_pool, frame_done;

  maxpool_relu1 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .conv_in_1      (conv_in_1),
    .conv_in_2      (conv_in_2),
    .conv_in_3      (conv_in_3),
    .pool_out_1     (pool_out_1),
    .pool_out_2     (pool_out_2),
    .pool_out_3     (pool_out_3),
    .valid_out_pool (valid_out_pool),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int p1;
    int p2;
    int p3;
    bit fd;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp = '{0, 0, 0, 1'b0, 0};
  int   img[3][H][W];
  int   errors = 0;
  int   checks = 0;
  int   n_pushed = 0;
  int   n_strobe = 0;

  function automatic void chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Reference: pool the stored frame directly from the image array.
  function automatic int win_max(input int ch, input int r, input int c);
    int m = 0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        int v = img[ch][r - dr][c - dc];
        if (v < 0) v = 0;
        if (v > m) m = v;
      end
    return m;
  endfunction

  task automatic send(input int r, input int c, input int a, input int b, input int d, input bit gaps);
    @(negedge clk);
    if (gaps) begin
      while ($urandom_range(99) < 40) begin
        valid_in  = 1'b0;
        conv_in_1 = DB'($urandom);
        conv_in_2 = DB'($urandom);
        conv_in_3 = DB'($urandom);
        @(negedge clk);
      end
    end
    valid_in  = 1'b1;
    conv_in_1 = DB'(a);
    conv_in_2 = DB'(b);
    conv_in_3 = DB'(d);
    img[0][r][c] = a;
    img[1][r][c] = b;
    img[2][r][c] = d;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      exp_t e;
      e.p1  = win_max(0, r, c);
      e.p2  = win_max(1, r, c);
      e.p3  = win_max(2, r, c);
      e.fd  = (r == H - 1) && (c == W - 1);
      e.cyc = cyc + 1;
      exp_q.push_back(e);
      n_pushed++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  // kind 0: ramp / -5 / alternating -100,+7; kind 1: one 16383 at corner k of window (0,0); kind 2: random
  task automatic frame(input int kind, input int k, input bit gaps, input int limit);
    int n = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        int a, b, d;
        if (n >= limit) return;
        case (kind)
          0: begin
            a = r * W + c;
            b = -5;
            d = (c % 2 == 0) ? -100 : 7;
          end
          1: begin
            a = (r == k / 2 && c == k % 2) ? 16383 : 1;
            b = a;
            d = a;
          end
          default: begin
            a = int'($urandom_range(32767)) - 16384;
            b = int'($urandom_range(32767)) - 16384;
            d = int'($urandom_range(32767)) - 16384;
          end
        endcase
        send(r, c, a, b, d, gaps);
        n++;
      end
  endtask

  // Monitor: pops the scoreboard on each strobe and checks that outputs hold between strobes.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (valid_out_pool) begin
        n_strobe++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pool_out_1", int'(pool_out_1), e.p1);
          chk("pool_out_2", int'(pool_out_2), e.p2);
          chk("pool_out_3", int'(pool_out_3), e.p3);
          chk("frame_done", int'(frame_done), int'(e.fd));
          chk("latency_cycle", int'(cyc), int'(e.cyc));
          last_exp = e;
        end
      end else begin
        chk("frame_done_idle", int'(frame_done), 0);
        chk("hold_out_1", int'(pool_out_1), last_exp.p1);
        chk("hold_out_3", int'(pool_out_3), last_exp.p3);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_pool_out_1", int'(pool_out_1), 0);
    chk("reset_pool_out_2", int'(pool_out_2), 0);
    chk("reset_pool_out_3", int'(pool_out_3), 0);
    chk("reset_valid", int'(valid_out_pool), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    rst_n = 1'b0;

    frame(0, 0, 1'b0, W * H);   // ramp + negative channels, continuous
    idle(3);
    frame(0, 0, 1'b1, W * H);   // same data with random gaps
    idle(2);
    for (int k = 0; k < 4; k++) frame(1, k, 1'b0, W * H);
    idle(2);

    frame(0, 0, 1'b0, 300);     // partial frame, then reset mid-frame
    @(posedge clk);
    #2;
    valid_in = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("midreset_pool_out_1", int'(pool_out_1), 0);
    chk("midreset_pool_out_2", int'(pool_out_2), 0);
    chk("midreset_pool_out_3", int'(pool_out_3), 0);
    chk("midreset_valid", int'(valid_out_pool), 0);
    n_pushed -= exp_q.size();
    exp_q.delete();
    last_exp = '{0, 0, 0, 1'b0, 0};
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;

    frame(0, 0, 1'b0, W * H);   // ramp after reset, then back-to-back ramp
    frame(0, 0, 1'b0, W * H);
    idle(2);
    frame(2, 0, 1'b1, W * H);   // random data with gaps
    frame(2, 0, 1'b0, W * H);

    idle(1);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    idle(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("strobe_count", n_strobe, n_pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
